// File: rtl/cv32e40s_pkg.sv
// Shared types for the cv32e40s prefetch controller: FSM state encoding and FIFO entry layout.
package cv32e40s_pkg;

  typedef enum logic [1:0] {
    PF_IDLE     = 2'd0,
    PF_RUN      = 2'd1,
    PF_ERR_HALT = 2'd2
  } prefetch_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } pf_entry_t;

endpackage

// File: rtl/cv32e40s_prefetch_ctrl_if.sv
// Fetch-side handshake and OBI instruction bus seen by the prefetch controller.
interface cv32e40s_prefetch_ctrl_if;

  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_err_o;
  logic        trans_valid_o;
  logic        trans_ready_i;
  logic [31:0] trans_addr_o;
  logic        resp_valid_i;
  logic [31:0] resp_rdata_i;
  logic        resp_err_i;

  modport master (
    input  branch_i, branch_addr_i, fetch_ready_i, trans_ready_i,
    input  resp_valid_i, resp_rdata_i, resp_err_i,
    output fetch_valid_o, fetch_rdata_o, fetch_addr_o, fetch_err_o,
    output trans_valid_o, trans_addr_o
  );

  modport slave (
    output branch_i, branch_addr_i, fetch_ready_i, trans_ready_i,
    output resp_valid_i, resp_rdata_i, resp_err_i,
    input  fetch_valid_o, fetch_rdata_o, fetch_addr_o, fetch_err_o,
    input  trans_valid_o, trans_addr_o
  );

endinterface

// File: rtl/cv32e40s_pf_fifo.sv
// DEPTH-entry circular FIFO of prefetched words with synchronous flush; storage itself is not reset.
module cv32e40s_pf_fifo
  import cv32e40s_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 push,
  input  pf_entry_t            push_data,
  input  logic                 pop,
  output pf_entry_t            head,
  output logic [CNT_WIDTH-1:0] cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pf_entry_t            mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 wr_en;
  logic                 rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A write into a full FIFO is only allowed when the head leaves in the same cycle
  assign wr_en = push & ((cnt_q != CNT_WIDTH'(DEPTH)) | pop);
  assign rd_en = pop & (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CNT_WIDTH'(wr_en) - CNT_WIDTH'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr_q] <= push_data;
  end

  assign head = mem[rd_ptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/cv32e40s_prefetch_ctrl.sv
// Prefetch controller: sequential OBI fetch with credit-based flow control, branch flush and discard.
// Optional CV32E40S_PF_ERR_STOP_EN: a kept error response halts fetching until the next branch.
module cv32e40s_prefetch_ctrl
  import cv32e40s_pkg::*;
#(
  parameter int DEPTH       = 3,
  parameter int MAX_OUTSTND = 2,
  parameter int CNT_WIDTH   = $clog2(DEPTH + 1),
  parameter int OUT_WIDTH   = $clog2(MAX_OUTSTND + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cv32e40s_prefetch_ctrl_if.master bus,
  output logic [OUT_WIDTH-1:0]     outstnd_cnt_o,
  output logic                     busy_o
);

  prefetch_state_e      st_q, st_d;
  logic [31:0]          req_addr_q, resp_addr_q;
  logic [31:0]          br_tgt;
  logic [31:0]          trans_addr;
  logic [OUT_WIDTH-1:0] outstnd_q, discard_q;
  logic [CNT_WIDTH-1:0] fifo_cnt;
  logic                 trans_valid;
  logic                 accept, push, pop, fifo_nempty, fetch_valid;
  pf_entry_t            head, push_data;

  // Room check counts only responses that will actually land in the FIFO
  function automatic logic has_credit(input logic [CNT_WIDTH-1:0] cnt,
                                      input logic [OUT_WIDTH-1:0] outstnd,
                                      input logic [OUT_WIDTH-1:0] discard);
    return (32'(cnt) + 32'(outstnd - discard)) < 32'(DEPTH);
  endfunction

  assign br_tgt      = bus.branch_addr_i & 32'hFFFF_FFFC;
  assign fifo_nempty = (fifo_cnt != '0);
  assign fetch_valid = fifo_nempty & ~bus.branch_i;
  assign pop         = fetch_valid & bus.fetch_ready_i;
  assign push        = bus.resp_valid_i & ~bus.branch_i & (discard_q == '0);
  assign accept      = trans_valid & bus.trans_ready_i;

  always_comb begin
    st_d        = st_q;
    trans_valid = 1'b0;
    trans_addr  = req_addr_q;
    if (bus.branch_i) begin
      st_d        = PF_RUN;
      trans_valid = (outstnd_q < OUT_WIDTH'(MAX_OUTSTND));
      trans_addr  = br_tgt;
    end else begin
      case (st_q)
        PF_RUN: begin
          trans_valid = (outstnd_q < OUT_WIDTH'(MAX_OUTSTND)) &&
                        has_credit(fifo_cnt, outstnd_q, discard_q);
`ifdef CV32E40S_PF_ERR_STOP_EN
          if (push && bus.resp_err_i) st_d = PF_ERR_HALT;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= PF_IDLE;
      req_addr_q  <= '0;
      resp_addr_q <= '0;
      outstnd_q   <= '0;
      discard_q   <= '0;
    end else begin
      st_q      <= st_d;
      outstnd_q <= outstnd_q + OUT_WIDTH'(accept) - OUT_WIDTH'(bus.resp_valid_i);
      if (accept)            req_addr_q <= trans_addr + 32'd4;
      else if (bus.branch_i) req_addr_q <= br_tgt;
      // Everything still in flight at a branch belongs to the old stream
      if (bus.branch_i)
        discard_q <= outstnd_q - OUT_WIDTH'(bus.resp_valid_i);
      else if (bus.resp_valid_i && discard_q != '0)
        discard_q <= discard_q - OUT_WIDTH'(1);
      if (bus.branch_i) resp_addr_q <= br_tgt;
      else if (push)    resp_addr_q <= resp_addr_q + 32'd4;
    end
  end

  assign push_data.rdata = bus.resp_rdata_i;
  assign push_data.addr  = resp_addr_q;
  assign push_data.err   = bus.resp_err_i;

  cv32e40s_pf_fifo #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.branch_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .cnt       (fifo_cnt)
  );

  assign bus.trans_valid_o = trans_valid;
  assign bus.trans_addr_o  = trans_addr;
  assign bus.fetch_valid_o = fetch_valid;
  // Unreset storage is masked so the fetch outputs read zero while empty
  assign bus.fetch_rdata_o = fifo_nempty ? head.rdata : '0;
  assign bus.fetch_addr_o  = fifo_nempty ? head.addr  : '0;
  assign bus.fetch_err_o   = fifo_nempty & head.err;
  assign outstnd_cnt_o     = outstnd_q;
  assign busy_o            = (outstnd_q != '0) | fifo_nempty;

endmodule

// File: tb/tb_cv32e40s_prefetch_ctrl.sv
// Directed table-driven bench for cv32e40s_prefetch_ctrl (DEPTH=3, MAX_OUTSTND=2).
module tb_cv32e40s_prefetch_ctrl;
  import cv32e40s_pkg::*;

`ifdef CV32E40S_PF_ERR_STOP_EN
  localparam bit ERR_STOP = 1'b1;
`else
  localparam bit ERR_STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] outstnd;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  cv32e40s_prefetch_ctrl_if pf_if ();

  cv32e40s_prefetch_ctrl #(.DEPTH(3), .MAX_OUTSTND(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (pf_if),
    .outstnd_cnt_o (outstnd),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  typedef struct {
    bit        rst;
    bit        br;
    bit [31:0] baddr;
    bit        fr;
    bit        tr;
    bit        rv;
    bit [31:0] rdata;
    bit        rerr;
    bit        e_tv;
    bit [31:0] e_taddr;
    bit        e_fv;
    bit [31:0] e_faddr;
    bit [31:0] e_frdata;
    bit        e_ferr;
    bit [1:0]  e_out;
    bit        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit br, bit [31:0] baddr, bit fr, bit tr, bit rv,
                              bit [31:0] rdata, bit rerr, bit e_tv, bit [31:0] e_taddr,
                              bit e_fv, bit [31:0] e_faddr, bit [31:0] e_frdata, bit e_ferr,
                              bit [1:0] e_out, bit e_busy);
    vec_t v;
    v.rst = rst; v.br = br; v.baddr = baddr; v.fr = fr; v.tr = tr; v.rv = rv;
    v.rdata = rdata; v.rerr = rerr; v.e_tv = e_tv; v.e_taddr = e_taddr; v.e_fv = e_fv;
    v.e_faddr = e_faddr; v.e_frdata = e_frdata; v.e_ferr = e_ferr; v.e_out = e_out;
    v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit br, input bit [31:0] baddr, input bit fr, input bit tr,
                       input bit rv, input bit [31:0] rdata, input bit rerr);
    pf_if.branch_i      = br;
    pf_if.branch_addr_i = baddr;
    pf_if.fetch_ready_i = fr;
    pf_if.trans_ready_i = tr;
    pf_if.resp_valid_i  = rv;
    pf_if.resp_rdata_i  = rdata;
    pf_if.resp_err_i    = rerr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    // 1: idle after reset
    vecs.push_back(mk(1,0,0,           0,1,0,0,0,           0,0,            0,0,0,0,                 0,0));
    vecs.push_back(mk(0,0,0,           0,1,0,0,0,           0,0,            0,0,0,0,                 0,0));
    vecs.push_back(mk(0,0,0,           0,1,0,0,0,           0,0,            0,0,0,0,                 0,0));
    // 2: fill the FIFO, then stall until a pop frees a slot
    vecs.push_back(mk(1,1,'h100,       0,1,0,0,0,           1,'h100,        0,0,0,0,                 0,0));
    vecs.push_back(mk(0,0,0,           0,1,1,'hA100,0,      1,'h104,        0,0,0,0,                 1,1));
    vecs.push_back(mk(0,0,0,           0,1,1,'hA104,0,      1,'h108,        1,'h100,'hA100,0,        1,1));
    vecs.push_back(mk(0,0,0,           0,1,1,'hA108,0,      0,'h10C,        1,'h100,'hA100,0,        1,1));
    vecs.push_back(mk(0,0,0,           0,1,0,0,0,           0,'h10C,        1,'h100,'hA100,0,        0,1));
    vecs.push_back(mk(0,0,0,           1,1,0,0,0,           0,'h10C,        1,'h100,'hA100,0,        0,1));
    vecs.push_back(mk(0,0,0,           0,1,0,0,0,           1,'h10C,        1,'h104,'hA104,0,        0,1));
    // 3: branch with two in flight, both old responses dropped
    vecs.push_back(mk(1,1,'h200,       0,1,0,0,0,           1,'h200,        0,0,0,0,                 0,0));
    vecs.push_back(mk(0,0,0,           0,1,0,0,0,           1,'h204,        0,0,0,0,                 1,1));
    vecs.push_back(mk(0,1,'h402,       0,0,0,0,0,           0,'h400,        0,0,0,0,                 2,1));
    vecs.push_back(mk(0,0,0,           0,1,1,'hDEAD0200,0,  0,'h400,        0,0,0,0,                 2,1));
    vecs.push_back(mk(0,0,0,           0,1,1,'hDEAD0204,0,  1,'h400,        0,0,0,0,                 1,1));
    vecs.push_back(mk(0,0,0,           0,1,1,'hB400,0,      1,'h404,        0,0,0,0,                 1,1));
    vecs.push_back(mk(0,0,0,           0,0,0,0,0,           1,'h408,        1,'h400,'hB400,0,        1,1));
    vecs.push_back(mk(0,0,0,           0,0,0,0,0,           1,'h408,        1,'h400,'hB400,0,        1,1));
    // 4: address wrap at the top of memory
    vecs.push_back(mk(1,1,'hFFFFFFF8,  0,1,0,0,0,           1,'hFFFFFFF8,   0,0,0,0,                 0,0));
    vecs.push_back(mk(0,0,0,           0,1,1,'hC0,0,        1,'hFFFFFFFC,   0,0,0,0,                 1,1));
    vecs.push_back(mk(0,0,0,           1,1,1,'hC1,0,        1,'h0,          1,'hFFFFFFF8,'hC0,0,     1,1));
    vecs.push_back(mk(0,0,0,           1,1,1,'hC2,0,        1,'h4,          1,'hFFFFFFFC,'hC1,0,     1,1));
    vecs.push_back(mk(0,0,0,           1,0,0,0,0,           1,'h8,          1,'h0,'hC2,0,            1,1));
    // 5: error response on 0x304
    vecs.push_back(mk(1,1,'h300,       0,1,0,0,0,           1,'h300,        0,0,0,0,                 0,0));
    vecs.push_back(mk(0,0,0,           0,1,1,'hE300,0,      1,'h304,        0,0,0,0,                 1,1));
    vecs.push_back(mk(0,0,0,           1,1,1,'hE304,1,      1,'h308,        1,'h300,'hE300,0,        1,1));
    vecs.push_back(mk(0,0,0,           0,1,0,0,0,           !ERR_STOP,'h30C, 1,'h304,'hE304,1,       1,1));
    vecs.push_back(mk(0,0,0,           0,1,0,0,0,           0,ERR_STOP ? 'h30C : 'h310,
                      1,'h304,'hE304,1, ERR_STOP ? 2'd1 : 2'd2, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].br, vecs[i].baddr, vecs[i].fr, vecs[i].tr, vecs[i].rv,
            vecs[i].rdata, vecs[i].rerr);
      #4;
      chk($sformatf("v%0d trans_valid", i), 32'(pf_if.trans_valid_o), 32'(vecs[i].e_tv));
      chk($sformatf("v%0d trans_addr", i), pf_if.trans_addr_o, vecs[i].e_taddr);
      chk($sformatf("v%0d fetch_valid", i), 32'(pf_if.fetch_valid_o), 32'(vecs[i].e_fv));
      chk($sformatf("v%0d outstnd", i), 32'(outstnd), 32'(vecs[i].e_out));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_fv) begin
        chk($sformatf("v%0d fetch_addr", i), pf_if.fetch_addr_o, vecs[i].e_faddr);
        chk($sformatf("v%0d fetch_rdata", i), pf_if.fetch_rdata_o, vecs[i].e_frdata);
        chk($sformatf("v%0d fetch_err", i), 32'(pf_if.fetch_err_o), 32'(vecs[i].e_ferr));
      end
      @(posedge clk);
      #1;
    end

    // 6: asynchronous reset with two outstanding and a buffered word
    do_reset();
    drive(1, 'h500, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 1, 'h55, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("pre_rst outstnd", 32'(outstnd), 32'd2);
    chk("pre_rst fetch_valid", 32'(pf_if.fetch_valid_o), 32'd1);
    chk("pre_rst fetch_addr", pf_if.fetch_addr_o, 32'h500);
    rst_n = 1'b0;
    #1;
    chk("rst trans_valid", 32'(pf_if.trans_valid_o), 32'd0);
    chk("rst trans_addr", pf_if.trans_addr_o, 32'd0);
    chk("rst fetch_valid", 32'(pf_if.fetch_valid_o), 32'd0);
    chk("rst fetch_rdata", pf_if.fetch_rdata_o, 32'd0);
    chk("rst fetch_addr", pf_if.fetch_addr_o, 32'd0);
    chk("rst fetch_err", 32'(pf_if.fetch_err_o), 32'd0);
    chk("rst outstnd", 32'(outstnd), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      #4;
      chk($sformatf("post_rst%0d trans_valid", k), 32'(pf_if.trans_valid_o), 32'd0);
      chk($sformatf("post_rst%0d busy", k), 32'(busy), 32'd0);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
